// File: rtl/elevator_scheduler_if.sv
// rtl/elevator_scheduler_if.sv - request/status bundle between floor detectors, scheduler and display logic
interface elevator_scheduler_if #(
    parameter int FLOORS  = 10,
    parameter int FLOOR_W = 4
);
    logic [FLOORS-1:0]  is_requested;
    logic [FLOORS-1:0]  request_clear;
    logic [FLOOR_W-1:0] current_floor;
    logic               direction;
    logic               moving;
    logic               door_open;
    logic [1:0]         sched_state;

    // Detector / display side
    modport master (
        output is_requested,
        input  request_clear,
        input  current_floor,
        input  direction,
        input  moving,
        input  door_open,
        input  sched_state
    );

    // Scheduler side
    modport slave (
        input  is_requested,
        output request_clear,
        output current_floor,
        output direction,
        output moving,
        output door_open,
        output sched_state
    );
endinterface

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - single-car SCAN scheduler driving floor, direction, door and clear pulses
module elevator_scheduler #(
    parameter int FLOORS        = 10,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    elevator_scheduler_if.slave  bus
);
    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_ARRIVE = 2'd2,
        S_DOOR   = 2'd3
    } state_t;

    state_t             r_state;
    logic [FLOOR_W-1:0] r_floor;
    logic               r_dir;
    logic [CNT_W-1:0]   r_cnt;
    logic [FLOORS-1:0]  r_clear;
    logic               r_moving;
    logic               r_door;

    state_t             w_state_nxt;
    logic [FLOOR_W-1:0] w_floor_nxt;
    logic               w_dir_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [FLOORS-1:0]  w_clear_nxt;
    logic               w_here;
    logic               w_above;
    logic               w_below;
    logic               w_ahead;
    logic               w_behind;

    // Classify pending requests relative to the car's current floor
    always_comb begin
        w_here  = 1'b0;
        w_above = 1'b0;
        w_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (bus.is_requested[i]) begin
                if (i > int'(r_floor)) begin
                    w_above = 1'b1;
                end else if (i < int'(r_floor)) begin
                    w_below = 1'b1;
                end else begin
                    w_here = 1'b1;
                end
            end
        end
        w_ahead  = r_dir ? w_above : w_below;
        w_behind = r_dir ? w_below : w_above;
    end

    // Next-state: SCAN decision in IDLE/ARRIVE, timed travel and door dwell
    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = r_floor;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_clear_nxt = '0;
        case (r_state)
            S_IDLE, S_ARRIVE: begin
                w_cnt_nxt = '0;
                if (w_here) begin
                    w_state_nxt = S_DOOR;
                    w_clear_nxt = FLOORS'(1) << r_floor;
                end else if (w_ahead) begin
                    w_state_nxt = S_MOVE;
                end else if (w_behind) begin
                    w_state_nxt = S_MOVE;
                    w_dir_nxt   = ~r_dir;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MOVE: begin
                if (r_cnt == CNT_W'(TRAVEL_CYCLES - 1)) begin
                    w_state_nxt = S_ARRIVE;
                    w_cnt_nxt   = '0;
                    w_floor_nxt = r_dir ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DOOR: begin
                if (r_cnt == CNT_W'(DOOR_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs; status flags follow the state on the same edge
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_floor  <= '0;
            r_dir    <= 1'b1;
            r_cnt    <= '0;
            r_clear  <= '0;
            r_moving <= 1'b0;
            r_door   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_floor  <= w_floor_nxt;
            r_dir    <= w_dir_nxt;
            r_cnt    <= w_cnt_nxt;
            r_clear  <= w_clear_nxt;
            r_moving <= (w_state_nxt == S_MOVE);
            r_door   <= (w_state_nxt == S_DOOR);
        end
    end

    assign bus.request_clear = r_clear;
    assign bus.current_floor = r_floor;
    assign bus.direction     = r_dir;
    assign bus.moving        = r_moving;
    assign bus.door_open     = r_door;
    assign bus.sched_state   = r_state;
endmodule
